fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
// Fetch-stage PC generator and redirect receiver. Consumes the EX-stage branch
// decision (taken flag + target), owns the architectural fetch PC, issues
// instruction-memory requests and delivers {pc, instr} to the IF/ID register.
// Squashes wrong-path fetches and drives the IF/ID and ID/EX flush strobes.
// PARAMETERS
// RESET_PC  32'h0000_0000  first fetch address after reset
// NOP_INSTR 32'h0000_0013  instruction presented on if_instr_out when invalid
// PORTS
// clk                input   1   rising-edge clock
// rst                input   1   synchronous, active-high reset
// stall_in           input   1   hazard unit: hold IF/ID payload
// branch_taken_in    input   1   EX-stage redirect request
// branch_target_in   input  32   redirect address
// imem_req_valid_out output  1   fetch request valid
// imem_req_addr_out  output 32   fetch address
// imem_req_ready_in  input   1   memory accepts request this cycle
// imem_rsp_valid_in  input   1   instruction word valid
// imem_rsp_data_in   input  32   instruction word
// if_valid_out       output  1   IF/ID payload valid
// if_pc_out          output 32   PC of if_instr_out
// if_instr_out       output 32   fetched instruction
// flush_ifid_out     output  1   squash IF/ID (combinational)
// flush_idex_out     output  1   squash ID/EX (combinational)
// misaligned_out     output  1   1-cycle pulse: redirect target[1:0]!=0
// BEHAVIOUR
// - Reset (rst=1 at edge): pc_q=RESET_PC, state=FETCH, drop=0, buffer empty;
//   outputs: req_valid=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, flush=0,
//   misaligned=0. rsp_valid ignored while rst=1. Reset mid-op discards all.
// - States: FETCH (req_valid=1, addr=pc_q), WAIT (req accepted, awaiting rsp).
//   FETCH: on ready -> WAIT, req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32).
//   WAIT: req_valid=0; on rsp_valid -> FETCH. One outstanding request max.
// - Request is uncommitted until handshake: addr may change while ready=0.
// - Delivery: rsp (drop=0) loads if_* at next edge if stall_in=0 or if_valid=0;
//   else into 1-entry buffer. Buffer drains into if_* on first stall_in=0 edge.
//   FETCH not re-entered while buffer full (no loss, no overwrite).
//   if_valid drops to 0 on an unstalled edge with nothing new to deliver.
// - Latency: ready=1, 1-cycle memory -> req at cycle 0, if_valid at cycle 2;
//   throughput 1 instr / 2 cycles.
// - Redirect (branch_taken_in=1, priority over stall and everything else):
//   flush_ifid_out=flush_idex_out=branch_taken_in & ~rst, same cycle.
//   Next edge: pc_q<={target[31:2],2'b00}; if_valid<=0; buffer cleared;
//   misaligned_out<=|target[1:0] (cleared the following cycle).
//   In FETCH: state stays FETCH; if handshake same cycle -> WAIT with drop=1.
//   In WAIT without rsp: drop<=1, remain WAIT. In WAIT with rsp same cycle:
//   rsp discarded, -> FETCH, drop stays 0.
//   rsp arriving with drop=1: discarded, drop<=0, -> FETCH.
// - Back-to-back redirects: last one wins; flush asserted each cycle.
// TESTING
// 1 Reset, ready=1, 1-cycle rsp -> req addrs 0,4,8; if_pc 0,4,8 valid at cyc 2,4,6.
// 2 Taken to 0x100 while req 0x8 in WAIT -> flush pulse same cycle, rsp 0x8
//   dropped, next req 0x100, if_pc 0x100 only valid entry after.
// 3 stall_in high 3 cycles with rsp arriving -> if_* frozen, buffered instr
//   appears edge after stall low, no fetch issued while buffer full.
// 4 Target 0x102 -> misaligned_out 1 cycle, next req addr 0x100.
// 5 RESET_PC=32'hFFFF_FFFC -> req addrs 0xFFFF_FFFC then 0x0000_0000.
// 6 rst during WAIT with rsp pending -> outputs at reset values, next req RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch-stage PC generator and redirect receiver. Owns the architectural fetch
// PC, issues one instruction-memory request at a time, and hands {pc, instr}
// to the IF/ID register. A taken branch from EX redirects the PC, squashes the
// in-flight wrong-path fetch, and raises the IF/ID and ID/EX flush strobes in
// the same cycle.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   stall_in            hazard unit: hold the IF/ID payload
//   branch_taken_in     EX-stage redirect request
//   branch_target_in    redirect address (low two bits ignored for the PC)
//   imem_req_valid_out  fetch request valid
//   imem_req_addr_out   fetch address
//   imem_req_ready_in   memory accepts the request this cycle
//   imem_rsp_valid_in   instruction word valid
//   imem_rsp_data_in    instruction word
//   if_valid_out        IF/ID payload valid
//   if_pc_out           PC of if_instr_out
//   if_instr_out        fetched instruction (NOP_INSTR when invalid)
//   flush_ifid_out      squash IF/ID (combinational)
//   flush_idex_out      squash ID/EX (combinational)
//   misaligned_out      one-cycle pulse: redirect target[1:0] != 0
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic        imem_req_valid_out,
    output logic [31:0] imem_req_addr_out,
    input  logic        imem_req_ready_in,
    input  logic        imem_rsp_valid_in,
    input  logic [31:0] imem_rsp_data_in,
    output logic        if_valid_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_instr_out,
    output logic        flush_ifid_out,
    output logic        flush_idex_out,
    output logic        misaligned_out
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        drop_q;
    logic        misaligned_q;

    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;

    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;

    logic        req_fire;
    logic        rsp_hit;
    logic        rsp_keep;
    logic        deliver_ok;
    logic        load_from_buf;
    logic        load_from_rsp;
    logic        load_buf;
    logic [31:0] redirect_pc;

    // A new request is held off while the skid buffer is occupied so a
    // response can never arrive with nowhere to go.
    assign imem_req_valid_out = (state_q == ST_FETCH) && !buf_valid_q && !rst;
    assign imem_req_addr_out  = pc_q;
    assign req_fire           = imem_req_valid_out && imem_req_ready_in;

    // Responses are only meaningful while a request is outstanding.
    assign rsp_hit     = (state_q == ST_WAIT) && imem_rsp_valid_in;
    // A redirect in the same cycle as the response makes it wrong-path too.
    assign rsp_keep    = rsp_hit && !drop_q && !branch_taken_in;

    assign redirect_pc = {branch_target_in[31:2], 2'b00};

    // IF/ID may take new data when not stalled, or when it holds nothing.
    assign deliver_ok    = !stall_in || !if_valid_q;
    assign load_from_buf = !rst && !branch_taken_in && deliver_ok && buf_valid_q;
    assign load_from_rsp = !rst && !branch_taken_in && deliver_ok && !buf_valid_q && rsp_keep;
    assign load_buf      = !rst && !branch_taken_in && !deliver_ok && rsp_keep;

    assign flush_ifid_out = branch_taken_in && !rst;
    assign flush_idex_out = branch_taken_in && !rst;
    assign misaligned_out = misaligned_q;

    assign if_valid_out = if_valid_q;
    assign if_pc_out    = if_pc_q;
    assign if_instr_out = if_valid_q ? if_instr_q : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (req_fire) state_d = ST_WAIT;
            ST_WAIT:  if (rsp_hit)  state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // PC, wrong-path tracking and misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            if (req_fire) begin
                pc_q <= pc_q + 32'd4;
            end
            // Redirect wins over the sequential increment.
            if (branch_taken_in) begin
                pc_q <= redirect_pc;
            end

            if (state_q == ST_FETCH) begin
                drop_q <= req_fire && branch_taken_in;
            end else if (rsp_hit) begin
                drop_q <= 1'b0;
            end else if (branch_taken_in) begin
                drop_q <= 1'b1;
            end

            misaligned_q <= branch_taken_in && (branch_target_in[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_pc_q <= pc_q;
        end
    end

    // IF/ID payload and skid buffer: valid flags
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'd0;
            buf_valid_q <= 1'b0;
        end else if (branch_taken_in) begin
            if_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else if (deliver_ok) begin
            if (buf_valid_q) begin
                if_valid_q  <= 1'b1;
                if_pc_q     <= buf_pc_q;
                buf_valid_q <= 1'b0;
            end else if (rsp_keep) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= req_pc_q;
            end else begin
                if_valid_q <= 1'b0;
            end
        end else if (rsp_keep) begin
            buf_valid_q <= 1'b1;
        end
    end

    // Payload data words follow the valid-flag load decisions above.
    always_ff @(posedge clk) begin
        if (load_from_buf) begin
            if_instr_q <= buf_instr_q;
        end else if (load_from_rsp) begin
            if_instr_q <= imem_rsp_data_in;
        end
        if (load_buf) begin
            buf_pc_q    <= req_pc_q;
            buf_instr_q <= imem_rsp_data_in;
        end
    end

endmodule
